// File: rtl/bsg_mem_1rw_sync_mask_write_byte_banked_if.sv
// Request/response bundle for the banked byte-masked RAM: valid/ready requests in,
// valid/yumi read responses out. The master modport is the requester/consumer side.
interface bsg_mem_1rw_sync_mask_write_byte_banked_if #(
  parameter int addr_width_p = 9,
  parameter int data_width_p = 64
) ();

  logic                      v_i;
  logic                      ready_o;
  logic                      w_i;
  logic [addr_width_p-1:0]   addr_i;
  logic [data_width_p-1:0]   data_i;
  logic [data_width_p/8-1:0] write_mask_i;
  logic                      v_o;
  logic [data_width_p-1:0]   data_o;
  logic                      yumi_i;

  modport master (
    output v_i, w_i, addr_i, data_i, write_mask_i, yumi_i,
    input  ready_o, v_o, data_o
  );

  modport slave (
    input  v_i, w_i, addr_i, data_i, write_mask_i, yumi_i,
    output ready_o, v_o, data_o
  );

endinterface

// File: rtl/bsg_mem_1rw_sync_mask_write_byte_banked.sv
// Word-interleaved banked single-port RAM with byte-masked writes, 1-cycle reads held until yumi.
// Optional BSG_MEM_BANKED_WRITE_ACK_EN: every accepted write also returns a zero-data response.
module bsg_mem_1rw_sync_mask_write_byte_banked #(
  parameter int els_p             = 512,
  parameter int data_width_p      = 64,
  parameter int num_banks_p       = 2,
  parameter int latch_last_read_p = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  bsg_mem_1rw_sync_mask_write_byte_banked_if.slave bus
);

  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  localparam int addr_width_lp       = safe_clog2(els_p);
  localparam int bank_sel_width_lp   = safe_clog2(num_banks_p);
  localparam int write_mask_width_lp = data_width_p / 8;
  localparam int sel_bits_lp         = $clog2(num_banks_p);
  localparam int rows_lp             = els_p / num_banks_p;
  localparam int row_width_lp        = safe_clog2(rows_lp);

  logic [addr_width_lp-1:0]       addr;
  logic [bank_sel_width_lp-1:0]   bank_w;
  logic [row_width_lp-1:0]        row_w;
  logic [data_width_p-1:0]        wmask_bits;
  logic [num_banks_p-1:0]         bank_en;
  logic [data_width_p-1:0]        bank_dout [num_banks_p];
  logic                           accept;

  logic                           v_q, v_d;
  logic                           fresh_q, fresh_d;
  logic                           wack_q, wack_d;
  logic [bank_sel_width_lp-1:0]   sel_q, sel_d;
  logic [data_width_p-1:0]        latch_q, latch_d;

  assign addr        = bus.addr_i;
  assign row_w       = row_width_lp'(addr >> sel_bits_lp);
  assign bus.ready_o = ~v_q | bus.yumi_i;
  assign accept      = bus.v_i & bus.ready_o;

  if (num_banks_p == 1) begin : g_one_bank
    assign bank_w = '0;
  end else begin : g_multi_bank
    assign bank_w = addr[sel_bits_lp-1:0];
  end

  always_comb begin
    for (int i = 0; i < write_mask_width_lp; i++) begin
      wmask_bits[8*i +: 8] = {8{bus.write_mask_i[i]}};
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    bank_en = '0;
    if (accept) bank_en[bank_w] = 1'b1;
  end

  for (genvar b = 0; b < num_banks_p; b++) begin : g_bank
    logic [data_width_p-1:0] mem_q [rows_lp];
    logic [data_width_p-1:0] dout_q;

    // NOTE: the array and its output register have no reset; RAM macros cannot be cleared and contents start undefined.
    always_ff @(posedge clk_i) begin
      if (bank_en[b]) begin
        if (bus.w_i) mem_q[row_w] <= (mem_q[row_w] & ~wmask_bits) | (bus.data_i & wmask_bits);
        else         dout_q       <= mem_q[row_w];
      end
    end

    assign bank_dout[b] = dout_q;
  end

  // fresh_q marks the cycle right after a bank read, when data comes straight from the bank.
  always_comb begin
    v_d     = v_q;
    fresh_d = 1'b0;
    wack_d  = wack_q;
    sel_d   = sel_q;
    latch_d = fresh_q ? bank_dout[sel_q] : latch_q;
    if (accept && !bus.w_i) begin
      v_d     = 1'b1;
      fresh_d = 1'b1;
      wack_d  = 1'b0;
      sel_d   = bank_w;
    end
`ifdef BSG_MEM_BANKED_WRITE_ACK_EN
    else if (accept && bus.w_i) begin
      v_d    = 1'b1;
      wack_d = 1'b1;
    end
`endif
    else if (bus.yumi_i) begin
      v_d    = 1'b0;
      wack_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_q     <= 1'b0;
      fresh_q <= 1'b0;
      wack_q  <= 1'b0;
      sel_q   <= '0;
      latch_q <= '0;
    end else begin
      v_q     <= v_d;
      fresh_q <= fresh_d;
      wack_q  <= wack_d;
      sel_q   <= sel_d;
      latch_q <= latch_d;
    end
  end

  assign bus.v_o = v_q;

  always_comb begin
    if (wack_q)                      bus.data_o = '0;
    else if (fresh_q)                bus.data_o = bank_dout[sel_q];
    else if (v_q)                    bus.data_o = latch_q;
    else if (latch_last_read_p != 0) bus.data_o = latch_q;
    else                             bus.data_o = '0;
  end

`ifndef SYNTHESIS
  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) bus.yumi_i |-> v_q)
    else $error("yumi_i asserted while v_o=0");
  a_addr_in_range: assert property (@(posedge clk_i) disable iff (reset_i) accept |-> (int'(addr) < els_p))
    else $error("address out of range on accepted request");
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_byte_banked.sv
// Directed bench for the banked byte-masked RAM (512x64, 2 banks, latch_last_read_p=1).
module tb_bsg_mem_1rw_sync_mask_write_byte_banked;

  localparam logic [63:0] D_MIX = 64'h11223344AAAAAAAA;
  localparam logic [63:0] D_DB  = 64'hDEADBEEF0BADF00D;

  logic clk = 1'b0;
  logic reset_i;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bsg_mem_1rw_sync_mask_write_byte_banked_if #(.addr_width_p(9), .data_width_p(64)) bus ();

  bsg_mem_1rw_sync_mask_write_byte_banked #(
    .els_p(512), .data_width_p(64), .num_banks_p(2), .latch_last_read_p(1)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  typedef struct {
    logic        v;
    logic        w;
    logic [8:0]  addr;
    logic [63:0] data;
    logic [7:0]  mask;
    logic        yumi;
    logic        ev;
    logic [63:0] ed;
    logic        er;
    logic [1:0]  een;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic w, input logic [8:0] addr,
                              input logic [63:0] data, input logic [7:0] mask, input logic yumi,
                              input logic ev, input logic [63:0] ed, input logic er,
                              input logic [1:0] een);
    vec_t r;
    r.v = v; r.w = w; r.addr = addr; r.data = data; r.mask = mask; r.yumi = yumi;
    r.ev = ev; r.ed = ed; r.er = er; r.een = een;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [8:0] addr,
                       input logic [63:0] data, input logic [7:0] mask, input logic yumi);
    bus.v_i = v; bus.w_i = w; bus.addr_i = addr;
    bus.data_i = data; bus.write_mask_i = mask; bus.yumi_i = yumi;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    drive(1'b0, 1'b0, 9'd0, 64'd0, 8'h00, 1'b0);

    //        v     w     addr     data               mask   yumi  ev    ed      er    een
    vecs.push_back(mk(1'b0, 1'b0, 9'd0,   64'd0,      8'h00, 1'b0, 1'b0, 64'd0,  1'b1, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 9'd5,   64'h1122334455667788, 8'hFF, 1'b0, 1'b0, 64'd0, 1'b1, 2'b10));
    vecs.push_back(mk(1'b1, 1'b1, 9'd5,   64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, 1'b0, 64'd0, 1'b1, 2'b10));
    vecs.push_back(mk(1'b1, 1'b0, 9'd5,   64'd0,      8'h00, 1'b0, 1'b0, 64'd0,  1'b1, 2'b10));
    vecs.push_back(mk(1'b0, 1'b0, 9'd0,   64'd0,      8'h00, 1'b0, 1'b1, D_MIX,  1'b0, 2'b00));
    vecs.push_back(mk(1'b1, 1'b0, 9'd0,   64'd0,      8'h00, 1'b0, 1'b1, D_MIX,  1'b0, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 9'd0,   64'hFF,     8'hFF, 1'b0, 1'b1, D_MIX,  1'b0, 2'b00));
    vecs.push_back(mk(1'b0, 1'b0, 9'd0,   64'd0,      8'h00, 1'b1, 1'b1, D_MIX,  1'b1, 2'b00));
    vecs.push_back(mk(1'b0, 1'b0, 9'd0,   64'd0,      8'h00, 1'b0, 1'b0, D_MIX,  1'b1, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 9'd0,   64'h0,      8'hFF, 1'b0, 1'b0, D_MIX,  1'b1, 2'b01));
    vecs.push_back(mk(1'b1, 1'b1, 9'd1,   64'h1,      8'hFF, 1'b0, 1'b0, D_MIX,  1'b1, 2'b10));
    vecs.push_back(mk(1'b1, 1'b1, 9'd510, 64'h1FE,    8'hFF, 1'b0, 1'b0, D_MIX,  1'b1, 2'b01));
    vecs.push_back(mk(1'b1, 1'b1, 9'd511, 64'h1FF,    8'hFF, 1'b0, 1'b0, D_MIX,  1'b1, 2'b10));
    vecs.push_back(mk(1'b1, 1'b0, 9'd0,   64'd0,      8'h00, 1'b0, 1'b0, D_MIX,  1'b1, 2'b01));
    vecs.push_back(mk(1'b1, 1'b0, 9'd1,   64'd0,      8'h00, 1'b1, 1'b1, 64'h0,  1'b1, 2'b10));
    vecs.push_back(mk(1'b1, 1'b0, 9'd510, 64'd0,      8'h00, 1'b1, 1'b1, 64'h1,  1'b1, 2'b01));
    vecs.push_back(mk(1'b1, 1'b0, 9'd511, 64'd0,      8'h00, 1'b1, 1'b1, 64'h1FE, 1'b1, 2'b10));
    vecs.push_back(mk(1'b0, 1'b0, 9'd0,   64'd0,      8'h00, 1'b1, 1'b1, 64'h1FF, 1'b1, 2'b00));
    vecs.push_back(mk(1'b0, 1'b0, 9'd0,   64'd0,      8'h00, 1'b0, 1'b0, 64'h1FF, 1'b1, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 9'd0,   64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b0, 1'b0, 64'h1FF, 1'b1, 2'b01));
    vecs.push_back(mk(1'b1, 1'b0, 9'd0,   64'd0,      8'h00, 1'b0, 1'b0, 64'h1FF, 1'b1, 2'b01));
    vecs.push_back(mk(1'b0, 1'b0, 9'd0,   64'd0,      8'h00, 1'b1, 1'b1, 64'h0,  1'b1, 2'b00));
    vecs.push_back(mk(1'b0, 1'b0, 9'd0,   64'd0,      8'h00, 1'b0, 1'b0, 64'h0,  1'b1, 2'b00));
    vecs.push_back(mk(1'b1, 1'b1, 9'd3,   D_DB,       8'hFF, 1'b0, 1'b0, 64'h0,  1'b1, 2'b10));
    vecs.push_back(mk(1'b1, 1'b0, 9'd3,   64'd0,      8'h00, 1'b0, 1'b0, 64'h0,  1'b1, 2'b10));
    vecs.push_back(mk(1'b0, 1'b0, 9'd0,   64'd0,      8'h00, 1'b1, 1'b1, D_DB,   1'b1, 2'b00));
    vecs.push_back(mk(1'b0, 1'b0, 9'd0,   64'd0,      8'h00, 1'b0, 1'b0, D_DB,   1'b1, 2'b00));
    vecs.push_back(mk(1'b1, 1'b0, 9'd1,   64'd0,      8'h00, 1'b0, 1'b0, D_DB,   1'b1, 2'b10));
    vecs.push_back(mk(1'b1, 1'b1, 9'd1,   64'h5555,   8'h01, 1'b1, 1'b1, 64'h1,  1'b1, 2'b10));
    vecs.push_back(mk(1'b1, 1'b0, 9'd1,   64'd0,      8'h00, 1'b0, 1'b0, 64'h1,  1'b1, 2'b10));
    vecs.push_back(mk(1'b0, 1'b0, 9'd0,   64'd0,      8'h00, 1'b1, 1'b1, 64'h55, 1'b1, 2'b00));
    vecs.push_back(mk(1'b0, 1'b0, 9'd0,   64'd0,      8'h00, 1'b0, 1'b0, 64'h55, 1'b1, 2'b00));

    repeat (3) @(posedge clk);
    #1;
    check("rst_v", 64'(bus.v_o), 64'd0);
    check("rst_data", bus.data_o, 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].w, vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].yumi);
      @(negedge clk);
      check($sformatf("vec%0d_v", i),     64'(bus.v_o),       64'(vecs[i].ev));
      check($sformatf("vec%0d_data", i),  bus.data_o,         vecs[i].ed);
      check($sformatf("vec%0d_ready", i), 64'(bus.ready_o),   64'(vecs[i].er));
      check($sformatf("vec%0d_bank", i),  64'(dut.bank_en),   64'(vecs[i].een));
      step();
    end
    drive(1'b0, 1'b0, 9'd0, 64'd0, 8'h00, 1'b0);

    // Write to addr 7: a response only when write acknowledgement is built in.
    drive(1'b1, 1'b1, 9'd7, 64'h77, 8'hFF, 1'b0);
    step();
    drive(1'b0, 1'b0, 9'd0, 64'd0, 8'h00, 1'b0);
`ifdef BSG_MEM_BANKED_WRITE_ACK_EN
    check("wack_v", 64'(bus.v_o), 64'd1);
    check("wack_data", bus.data_o, 64'd0);
    bus.yumi_i = 1'b1;
    step();
    bus.yumi_i = 1'b0;
`else
    check("wack_v", 64'(bus.v_o), 64'd0);
    check("wack_data", bus.data_o, 64'h55);
`endif
    drive(1'b1, 1'b0, 9'd7, 64'd0, 8'h00, 1'b0);
    step();
    drive(1'b0, 1'b0, 9'd0, 64'd0, 8'h00, 1'b0);
    check("rd7_v", 64'(bus.v_o), 64'd1);
    check("rd7_data", bus.data_o, 64'h77);
    bus.yumi_i = 1'b1;
    step();
    bus.yumi_i = 1'b0;

    // Reset while a read result is pending, then confirm memory survived.
    drive(1'b1, 1'b0, 9'd5, 64'd0, 8'h00, 1'b0);
    step();
    drive(1'b0, 1'b0, 9'd0, 64'd0, 8'h00, 1'b0);
    check("prerst_v", 64'(bus.v_o), 64'd1);
    reset_i = 1'b1;
    #1;
    check("midrst_v", 64'(bus.v_o), 64'd0);
    check("midrst_data", bus.data_o, 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    check("postrst_ready", 64'(bus.ready_o), 64'd1);
    step();
    drive(1'b1, 1'b0, 9'd5, 64'd0, 8'h00, 1'b0);
    step();
    drive(1'b0, 1'b0, 9'd0, 64'd0, 8'h00, 1'b0);
    check("postrst_rd_v", 64'(bus.v_o), 64'd1);
    check("postrst_rd_data", bus.data_o, D_MIX);
    bus.yumi_i = 1'b1;
    step();
    bus.yumi_i = 1'b0;
    check("postrst_done_v", 64'(bus.v_o), 64'd0);
    check("postrst_done_data", bus.data_o, D_MIX);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
